hamming_2d_serial_rx: RTL and testbench

Serial receive front-end for the 2D interleaved Hamming link. It accepts a bit-serial stream of 105-bit codewords, reassembles each frame, and decodes it through an instantiated `hamming_2d_decoder`. It presents the 44-bit payload plus error flag on a valid/ready output port and keeps saturating frame and error statistics. It sits between the serial line PHY and the payload consumer; the link's transmit end produces codewords with `hamming_2d_encoder`.

---
 rtl/hamming_2d_decoder.sv | 50 +++++
 rtl/hamming_2d_serial_rx.sv | 110 +++++++++++
 tb/tb_hamming_2d_serial_rx.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/hamming_2d_decoder.sv
// Product-code decoder for the 2D Hamming link: 7x15 array, rows Hamming(15,11), columns Hamming(7,4).
// Codeword bit r*15+c holds array row r, column c; payload sits at non-power-of-two positions of both axes.
module hamming_2d_decoder (
  input  logic [104:0] code_in,
  output logic [43:0]  decoded_out,
  output logic         error_detected
);
  logic [3:0]   row_syn [7];
  logic [2:0]   col_syn [15];
  logic [104:0] fixed;

  always_comb begin
    for (int r = 0; r < 7; r++) begin
      row_syn[r] = '0;
      for (int c = 0; c < 15; c++)
        if (code_in[r*15+c]) row_syn[r] = row_syn[r] ^ 4'(c + 1);
    end
    for (int c = 0; c < 15; c++) begin
      col_syn[c] = '0;
      for (int r = 0; r < 7; r++)
        if (code_in[r*15+c]) col_syn[c] = col_syn[c] ^ 3'(r + 1);
    end
  end

  // A bit is flipped only where its row syndrome names its column and its column syndrome names its row.
  always_comb begin
    error_detected = 1'b0;
    fixed = code_in;
    for (int r = 0; r < 7; r++)
      if (row_syn[r] != 4'd0) error_detected = 1'b1;
    for (int c = 0; c < 15; c++)
      if (col_syn[c] != 3'd0) error_detected = 1'b1;
    for (int r = 0; r < 7; r++)
      for (int c = 0; c < 15; c++)
        if (row_syn[r] == 4'(c + 1) && col_syn[c] == 3'(r + 1))
          fixed[r*15+c] = ~code_in[r*15+c];
  end

  always_comb begin
    int di;
    di = 0;
    decoded_out = '0;
    for (int r = 0; r < 7; r++)
      for (int c = 0; c < 15; c++)
        if ((((r + 1) & r) != 0) && (((c + 1) & c) != 0)) begin
          decoded_out[di] = fixed[r*15+c];
          di++;
        end
  end
endmodule

// File: rtl/hamming_2d_serial_rx.sv
// Serial receive front-end: assembles 105-bit frames, decodes them, and hands the payload
// out on a valid/ready port while keeping saturating frame/error statistics.
module hamming_2d_serial_rx #(
  parameter int MSB_FIRST = 1,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rx_valid,
  output logic             rx_ready,
  input  logic             rx_bit,
  input  logic             rx_sof,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [43:0]      out_data,
  output logic             out_err,
  output logic             sync_err,
  output logic [CNT_W-1:0] frame_cnt,
  output logic [CNT_W-1:0] err_cnt
);
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SHIFT  = 2'd1;
  localparam logic [1:0] DECODE = 2'd2;
  localparam logic [1:0] OUT    = 2'd3;

  logic [1:0]   state;
  logic [6:0]   bit_cnt;
  logic [104:0] word;
  logic [43:0]  dec_data;
  logic         dec_err;
  logic         accept;
  logic [6:0]   k;
  logic [6:0]   idx;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign rx_ready  = rst_n && (state == IDLE || state == SHIFT);
  assign accept    = rx_valid && rx_ready;
  assign out_valid = (state == OUT);
  assign k         = rx_sof ? 7'd0 : bit_cnt;
  assign idx       = (MSB_FIRST != 0) ? 7'd104 - k : k;

  hamming_2d_decoder u_dec (
    .code_in        (word),
    .decoded_out    (dec_data),
    .error_detected (dec_err)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      word      <= '0;
      out_data  <= '0;
      out_err   <= 1'b0;
      sync_err  <= 1'b0;
      frame_cnt <= '0;
      err_cnt   <= '0;
    end else begin
      sync_err <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (rx_sof) begin
              word      <= '0;
              word[idx] <= rx_bit;
              bit_cnt   <= 7'd1;
              state     <= SHIFT;
            end else begin
              sync_err <= 1'b1;
            end
          end
        end
        SHIFT: begin
          if (accept) begin
            // A fresh start-of-frame mid-frame restarts assembly from this bit.
            if (rx_sof) begin
              sync_err  <= 1'b1;
              word      <= '0;
              word[idx] <= rx_bit;
              bit_cnt   <= 7'd1;
            end else begin
              word[idx] <= rx_bit;
              if (bit_cnt == 7'd104) begin
                bit_cnt <= '0;
                state   <= DECODE;
              end else begin
                bit_cnt <= bit_cnt + 7'd1;
              end
            end
          end
        end
        DECODE: begin
          out_data <= dec_data;
          out_err  <= dec_err;
          state    <= OUT;
        end
        default: begin
          if (out_ready) begin
            frame_cnt <= sat_inc(frame_cnt);
            if (out_err) err_cnt <= sat_inc(err_cnt);
            state <= IDLE;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_hamming_2d_serial_rx.sv
// Directed bench: instance a is MSB-first with 16-bit counters, instance b is LSB-first with 2-bit counters.
module tb_hamming_2d_serial_rx;
  logic clk = 1'b0;
  logic rst_n_a, rst_n_b;
  logic rx_valid, rx_bit, rx_sof, out_ready;

  logic        a_rx_ready, a_out_valid, a_out_err, a_sync_err;
  logic [43:0] a_out_data;
  logic [15:0] a_frame_cnt, a_err_cnt;
  logic        b_rx_ready, b_out_valid, b_out_err, b_sync_err;
  logic [43:0] b_out_data;
  logic [1:0]  b_frame_cnt, b_err_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hamming_2d_serial_rx #(.MSB_FIRST(1), .CNT_W(16)) dut_a (
    .clk(clk), .rst_n(rst_n_a), .rx_valid(rx_valid), .rx_ready(a_rx_ready),
    .rx_bit(rx_bit), .rx_sof(rx_sof), .out_valid(a_out_valid), .out_ready(out_ready),
    .out_data(a_out_data), .out_err(a_out_err), .sync_err(a_sync_err),
    .frame_cnt(a_frame_cnt), .err_cnt(a_err_cnt)
  );

  hamming_2d_serial_rx #(.MSB_FIRST(0), .CNT_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n_b), .rx_valid(rx_valid), .rx_ready(b_rx_ready),
    .rx_bit(rx_bit), .rx_sof(rx_sof), .out_valid(b_out_valid), .out_ready(out_ready),
    .out_data(b_out_data), .out_err(b_out_err), .sync_err(b_sync_err),
    .frame_cnt(b_frame_cnt), .err_cnt(b_err_cnt)
  );

  // Reference encoder: data rows 2,4,5,6; data columns at non-power-of-two positions.
  function automatic logic [104:0] encode(input logic [43:0] d);
    logic [104:0] w;
    logic [3:0]   rs;
    logic [2:0]   cs;
    int           di;
    w = '0;
    di = 0;
    for (int r = 0; r < 7; r++)
      for (int c = 0; c < 15; c++)
        if ((((r + 1) & r) != 0) && (((c + 1) & c) != 0)) begin
          w[r*15+c] = d[di];
          di++;
        end
    for (int r = 2; r < 7; r++) begin
      rs = '0;
      for (int c = 0; c < 15; c++) if (w[r*15+c]) rs = rs ^ 4'(c + 1);
      w[r*15+0] = rs[0];
      w[r*15+1] = rs[1];
      w[r*15+3] = rs[2];
      w[r*15+7] = rs[3];
    end
    for (int c = 0; c < 15; c++) begin
      cs = '0;
      for (int r = 0; r < 7; r++) if (w[r*15+c]) cs = cs ^ 3'(r + 1);
      w[0*15+c] = cs[0];
      w[1*15+c] = cs[1];
      w[3*15+c] = cs[2];
    end
    return w;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_range(input logic [104:0] code, input bit msb, input int lo, input int hi);
    for (int k = lo; k <= hi; k++) begin
      rx_valid = 1'b1;
      rx_bit   = msb ? code[104-k] : code[k];
      rx_sof   = (k == 0);
      tick();
    end
    rx_valid = 1'b0;
    rx_sof   = 1'b0;
  endtask

  localparam logic [43:0] P1 = 44'h0AB_CDEF_1234;
  localparam logic [43:0] P2 = 44'h123_4567_89AB;
  localparam logic [43:0] P3 = 44'hFED_CBA9_8765;

  initial begin
    logic [104:0] cw1, cw1e, cw2, cw3, cw3e;
    cw1  = encode(P1);
    cw1e = cw1 ^ (105'd1 << 57);
    cw2  = encode(P2);
    cw3  = encode(P3);
    cw3e = cw3 ^ (105'd1 << 10);

    rst_n_a = 1'b0; rst_n_b = 1'b0;
    rx_valid = 1'b0; rx_bit = 1'b0; rx_sof = 1'b0; out_ready = 1'b1;
    tick(); tick();
    chk("a_reset_rx_ready", 64'(a_rx_ready), 64'd0);
    chk("a_reset_out_valid", 64'(a_out_valid), 64'd0);
    chk("a_reset_out_data", 64'(a_out_data), 64'd0);
    chk("a_reset_out_err", 64'(a_out_err), 64'd0);
    chk("a_reset_sync_err", 64'(a_sync_err), 64'd0);
    chk("a_reset_frame_cnt", 64'(a_frame_cnt), 64'd0);
    chk("a_reset_err_cnt", 64'(a_err_cnt), 64'd0);
    rst_n_a = 1'b1;
    #1;
    chk("a_rx_ready_after_reset", 64'(a_rx_ready), 64'd1);

    // clean frame, MSB first
    send_range(cw1, 1'b1, 0, 104);
    chk("clean_valid_low_n", 64'(a_out_valid), 64'd0);
    tick();
    chk("clean_valid_n1", 64'(a_out_valid), 64'd1);
    chk("clean_data", 64'(a_out_data), 64'(P1));
    chk("clean_err", 64'(a_out_err), 64'd0);
    chk("clean_rx_ready_low", 64'(a_rx_ready), 64'd0);
    tick();
    chk("clean_frame_cnt", 64'(a_frame_cnt), 64'd1);
    chk("clean_err_cnt", 64'(a_err_cnt), 64'd0);
    chk("clean_rx_ready_back", 64'(a_rx_ready), 64'd1);

    // single-bit error at codeword bit 57 is corrected and flagged
    send_range(cw1e, 1'b1, 0, 104);
    tick();
    chk("sbe_valid", 64'(a_out_valid), 64'd1);
    chk("sbe_data", 64'(a_out_data), 64'(P1));
    chk("sbe_err", 64'(a_out_err), 64'd1);
    tick();
    chk("sbe_frame_cnt", 64'(a_frame_cnt), 64'd2);
    chk("sbe_err_cnt", 64'(a_err_cnt), 64'd1);

    // backpressure for 20 cycles
    out_ready = 1'b0;
    send_range(cw2, 1'b1, 0, 104);
    tick();
    for (int i = 0; i < 20; i++) begin
      chk("bp_valid", 64'(a_out_valid), 64'd1);
      chk("bp_data", 64'(a_out_data), 64'(P2));
      chk("bp_rx_ready", 64'(a_rx_ready), 64'd0);
      tick();
    end
    chk("bp_frame_cnt_held", 64'(a_frame_cnt), 64'd2);
    out_ready = 1'b1;
    tick();
    chk("bp_valid_after_hs", 64'(a_out_valid), 64'd0);
    chk("bp_rx_ready_after_hs", 64'(a_rx_ready), 64'd1);
    chk("bp_frame_cnt", 64'(a_frame_cnt), 64'd3);

    // framing violations: stray bit in IDLE, then restart at bit 40
    rx_valid = 1'b1; rx_bit = 1'b1; rx_sof = 1'b0;
    tick();
    rx_valid = 1'b0;
    chk("sync_idle_pulse", 64'(a_sync_err), 64'd1);
    tick();
    chk("sync_idle_clear", 64'(a_sync_err), 64'd0);
    send_range(cw1, 1'b1, 0, 39);
    chk("sync_partial_no_err", 64'(a_sync_err), 64'd0);
    send_range(cw2, 1'b1, 0, 0);
    chk("sync_restart_pulse", 64'(a_sync_err), 64'd1);
    send_range(cw2, 1'b1, 1, 1);
    chk("sync_restart_clear", 64'(a_sync_err), 64'd0);
    send_range(cw2, 1'b1, 2, 104);
    tick();
    chk("sync_frame_valid", 64'(a_out_valid), 64'd1);
    chk("sync_frame_data", 64'(a_out_data), 64'(P2));
    chk("sync_frame_err", 64'(a_out_err), 64'd0);
    tick();
    chk("sync_frame_cnt", 64'(a_frame_cnt), 64'd4);

    // LSB-first instance: reset mid-frame, then a full frame
    rst_n_a = 1'b0;
    rst_n_b = 1'b1;
    tick();
    send_range(cw3, 1'b0, 0, 59);
    rst_n_b = 1'b0;
    #1;
    chk("b_rx_ready_in_reset", 64'(b_rx_ready), 64'd0);
    tick();
    chk("b_reset_out_valid", 64'(b_out_valid), 64'd0);
    chk("b_reset_out_data", 64'(b_out_data), 64'd0);
    chk("b_reset_sync_err", 64'(b_sync_err), 64'd0);
    chk("b_reset_frame_cnt", 64'(b_frame_cnt), 64'd0);
    rst_n_b = 1'b1;
    send_range(cw3, 1'b0, 0, 104);
    tick();
    chk("lsb_valid", 64'(b_out_valid), 64'd1);
    chk("lsb_data", 64'(b_out_data), 64'(P3));
    chk("lsb_err", 64'(b_out_err), 64'd0);
    tick();
    chk("lsb_frame_cnt", 64'(b_frame_cnt), 64'd1);

    // saturation with 2-bit counters
    rst_n_b = 1'b0;
    tick();
    rst_n_b = 1'b1;
    for (int f = 1; f <= 5; f++) begin
      send_range(cw3e, 1'b0, 0, 104);
      tick();
      chk("sat_data", 64'(b_out_data), 64'(P3));
      chk("sat_err", 64'(b_out_err), 64'd1);
      tick();
      chk("sat_frame_cnt", 64'(b_frame_cnt), 64'((f > 3) ? 3 : f));
      chk("sat_err_cnt", 64'(b_err_cnt), 64'((f > 3) ? 3 : f));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
